// File: rtl/id_stage.sv
// Decode stage for MIPS-style instructions: fields are extracted, extended and
// classified on entry, then held in a small FIFO of decoded entries.
// All outputs come from the head entry, so nothing flows combinationally from
// the in_* side to the out_* side.
module id_stage #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opcode,
  output logic [5:0]      out_func,
  output logic [4:0]      out_ra,
  output logic [4:0]      out_rb,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_jtarget,
  output logic [XLEN-1:0] out_pc,
  output logic [1:0]      out_itype
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [5:0]      opcode;
    logic [5:0]      func;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jtarget;
    logic [XLEN-1:0] pc;
    logic [1:0]      itype;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          dec;
  entry_t          head;
  logic            push, pop;
  logic [XLEN-1:0] pc_plus4;
  logic            zext;

  // Handshake status depends only on the registered occupancy.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Decode the incoming word into the form stored in the buffer.
  always_comb begin
    pc_plus4    = in_pc + XLEN'(4);
    zext        = ZEXT_LOGIC && (in_inst[31:26] == 6'h0C || in_inst[31:26] == 6'h0D ||
                                 in_inst[31:26] == 6'h0E);
    dec         = '0;
    dec.opcode  = in_inst[31:26];
    dec.func    = in_inst[5:0];
    dec.ra      = in_inst[25:21];
    dec.rb      = in_inst[20:16];
    dec.rd      = in_inst[15:11];
    dec.shamt   = in_inst[10:6];
    dec.imm     = zext ? {{(XLEN-16){1'b0}}, in_inst[15:0]}
                       : {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
    dec.jtarget = {pc_plus4[XLEN-1:28], in_inst[25:0], 2'b00};
    dec.pc      = in_pc;
    if (in_inst[31:26] == 6'h00)
      dec.itype = 2'd0;
    else if (in_inst[31:26] == 6'h02 || in_inst[31:26] == 6'h03)
      dec.itype = 2'd2;
    else
      dec.itype = 2'd1;
  end

  // Next-state for storage, pointers and occupancy; flush overrides everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the buffer and zeroes every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_opcode  = head.opcode;
  assign out_func    = head.func;
  assign out_ra      = head.ra;
  assign out_rb      = head.rb;
  assign out_rd      = head.rd;
  assign out_shamt   = head.shamt;
  assign out_imm     = head.imm;
  assign out_jtarget = head.jtarget;
  assign out_pc      = head.pc;
  assign out_itype   = head.itype;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a queue model of the decoded-entry buffer plus directed
// vectors. Two instances share stimulus, one with logical-immediate zero
// extension and one without.
module tb_id_stage;

  localparam int DEPTH = 2;

  logic        clk, rst, in_valid, in_ready, in_ready2, flush, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        out_valid, out_valid2;
  logic [5:0]  out_opcode, out_func, out_opcode2, out_func2;
  logic [4:0]  out_ra, out_rb, out_rd, out_shamt, out_ra2, out_rb2, out_rd2, out_shamt2;
  logic [31:0] out_imm, out_jtarget, out_pc, out_imm2, out_jtarget2, out_pc2;
  logic [1:0]  out_itype, out_itype2;

  id_stage #(.XLEN(32), .DEPTH(DEPTH), .ZEXT_LOGIC(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func(out_func), .out_ra(out_ra), .out_rb(out_rb),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm), .out_jtarget(out_jtarget),
    .out_pc(out_pc), .out_itype(out_itype));

  id_stage #(.XLEN(32), .DEPTH(DEPTH), .ZEXT_LOGIC(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .out_opcode(out_opcode2), .out_func(out_func2), .out_ra(out_ra2), .out_rb(out_rb2),
    .out_rd(out_rd2), .out_shamt(out_shamt2), .out_imm(out_imm2), .out_jtarget(out_jtarget2),
    .out_pc(out_pc2), .out_itype(out_itype2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } item_t;
  item_t model_q[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected fields derived straight from the instruction-set rules.
  function automatic logic [31:0] m_imm(input logic [31:0] inst, input bit zext_logic);
    int unsigned op, v;
    op = inst >> 26;
    v  = inst & 32'hFFFF;
    if (!(zext_logic && (op == 12 || op == 13 || op == 14)) && (v >= 32'h8000))
      v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [31:0] m_jt(input logic [31:0] inst, input logic [31:0] pc);
    return ((pc + 4) & 32'hF0000000) + ((inst % (1 << 26)) * 4);
  endfunction

  function automatic logic [31:0] m_itype(input logic [31:0] inst);
    int unsigned op;
    op = inst >> 26;
    if (op == 0) return 0;
    if (op == 2 || op == 3) return 2;
    return 1;
  endfunction

  // Model update: reset empties, flush empties, otherwise pop then push.
  always @(posedge clk or posedge rst) begin
    if (rst) model_q.delete();
    else if (flush) model_q.delete();
    else begin
      automatic int sz = model_q.size();
      automatic bit do_push = in_valid && (sz < DEPTH);
      if (out_ready && sz != 0) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{in_inst, in_pc});
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (checking && !rst) begin
      cmp("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < DEPTH});
      cmp("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      cmp("in_ready2", {31'd0, in_ready2}, {31'd0, model_q.size() < DEPTH});
      cmp("out_valid2", {31'd0, out_valid2}, {31'd0, model_q.size() != 0});
      if (model_q.size() != 0) begin
        automatic logic [31:0] i = model_q[0].inst;
        automatic logic [31:0] p = model_q[0].pc;
        cmp("opcode", {26'd0, out_opcode}, i >> 26);
        cmp("ra", {27'd0, out_ra}, (i >> 21) & 31);
        cmp("rb", {27'd0, out_rb}, (i >> 16) & 31);
        cmp("rd", {27'd0, out_rd}, (i >> 11) & 31);
        cmp("shamt", {27'd0, out_shamt}, (i >> 6) & 31);
        cmp("func", {26'd0, out_func}, i & 63);
        cmp("imm", out_imm, m_imm(i, 1'b1));
        cmp("imm2", out_imm2, m_imm(i, 1'b0));
        cmp("jtarget", out_jtarget, m_jt(i, p));
        cmp("jtarget2", out_jtarget2, m_jt(i, p));
        cmp("pc", out_pc, p);
        cmp("itype", {30'd0, out_itype}, m_itype(i));
        cmp("itype2", {30'd0, out_itype2}, m_itype(i));
        cmp("opcode2", {26'd0, out_opcode2}, i >> 26);
        cmp("pc2", out_pc2, p);
      end
    end
  end

  // Present one instruction for one cycle; caller is at posedge+1.
  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) begin
      @(posedge clk); #1;
    end
    cmp("drain_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  logic [31:0] tbl [8];

  initial begin
    tbl = '{32'h00221820, 32'h2001FFFF, 32'h3401FFFF, 32'h30028001,
            32'h38038000, 32'h0C001234, 32'h08000010, 32'h8C22FFFC};
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    cmp("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cmp("rst_opcode", {26'd0, out_opcode}, 32'd0);
    cmp("rst_imm", out_imm, 32'd0);
    cmp("rst_pc", out_pc, 32'd0);
    #20;
    @(negedge clk); rst = 1'b0; checking = 1'b1;
    @(posedge clk); #1;

    // R-type field split, one-edge latency
    offer(32'h00221820, 32'h0);
    cmp("r_valid", {31'd0, out_valid}, 32'd1);
    cmp("r_ra", {27'd0, out_ra}, 32'd1);
    cmp("r_rb", {27'd0, out_rb}, 32'd2);
    cmp("r_rd", {27'd0, out_rd}, 32'd3);
    cmp("r_shamt", {27'd0, out_shamt}, 32'd0);
    cmp("r_func", {26'd0, out_func}, 32'h20);
    cmp("r_itype", {30'd0, out_itype}, 32'd0);
    drain();

    // Sign vs zero extension
    offer(32'h2001FFFF, 32'h4);
    cmp("addi_imm", out_imm, 32'hFFFFFFFF);
    cmp("addi_itype", {30'd0, out_itype}, 32'd1);
    drain();
    offer(32'h3401FFFF, 32'h8);
    cmp("ori_imm_zext", out_imm, 32'h0000FFFF);
    cmp("ori_imm_sext", out_imm2, 32'hFFFFFFFF);
    drain();

    // Jump target
    offer(32'h08000010, 32'h40000000);
    cmp("j_target", out_jtarget, 32'h40000040);
    cmp("j_itype", {30'd0, out_itype}, 32'd2);
    drain();

    // Full buffer backpressure
    offer(32'h20010001, 32'h100);
    offer(32'h20020002, 32'h104);
    in_valid = 1'b1; in_inst = 32'h20030003; in_pc = 32'h108;
    cmp("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    cmp("full_hold_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    @(posedge clk); #1;
    cmp("pop1_pc", out_pc, 32'h104);
    cmp("pop1_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp("third_pc", out_pc, 32'h108);
    @(posedge clk); #1;
    cmp("after_third_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Flush discards buffered and offered entries
    offer(32'h20040004, 32'h200);
    offer(32'h20050005, 32'h204);
    in_valid = 1'b1; in_inst = 32'h20060006; in_pc = 32'h208; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    cmp("flush_valid", {31'd0, out_valid}, 32'd0);
    cmp("flush_in_ready", {31'd0, in_ready}, 32'd1);
    offer(32'h20070007, 32'h20C);
    cmp("post_flush_pc", out_pc, 32'h20C);
    drain();

    // Mixed traffic exercising pointer wrap and a flush mid-stream
    for (int k = 0; k < 48; k++) begin
      in_valid  = (k % 3) != 2;
      out_ready = (k % 5) < 3;
      flush     = (k == 30);
      in_inst   = tbl[k % 8] ^ (32'(k) << 6);
      in_pc     = 32'h1000 + 32'(k) * 4;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drain();

    // Asynchronous reset between edges with one entry buffered
    offer(32'h2008000A, 32'h300);
    cmp("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    cmp("arst_valid", {31'd0, out_valid}, 32'd0);
    cmp("arst_in_ready", {31'd0, in_ready}, 32'd1);
    cmp("arst_opcode", {26'd0, out_opcode}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    offer(32'h2009000B, 32'h304);
    cmp("post_rst_valid", {31'd0, out_valid}, 32'd1);
    cmp("post_rst_pc", out_pc, 32'h304);
    drain();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
